// File: rtl/cshm_fir_seq.sv
// cshm_fir_seq: sequencer for the computation-sharing-multiplier FIR datapath.
// Owns the sample delay line and the coefficient bank. For every accepted
// sample it walks each tap one coefficient nibble per cycle. It drives the
// shared odd-multiple mux select, then shifts, gates and accumulates the
// multiple that comes back on mux_out.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_data/in_valid    input sample offer; in_ready high only while idle
//   coef_we/addr/data   coefficient write port (addr >= TAPS ignored)
//   tap_sample          delay-line sample for the tap being processed
//   mux_select          odd-multiple select (0->x1 ... 7->x15)
//   mux_out             selected multiple, returned in the same cycle
//   out_data/out_valid  filter result, held until out_ready
module cshm_fir_seq #(
  parameter int unsigned TAPS  = 8,
  parameter int unsigned ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             coef_we,
  input  logic [3:0]       coef_addr,
  input  logic [7:0]       coef_data,
  output logic [7:0]       tap_sample,
  output logic [2:0]       mux_select,
  input  logic [15:0]      mux_out,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned IDX_W = $clog2(2 * TAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * TAPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       coef_q [TAPS];
  logic [7:0]       d_q    [TAPS];
  logic [ACC_W-1:0] acc_q;
  logic [IDX_W-1:0] idx_q;

  logic [TAP_W-1:0] tap;
  logic [3:0]       nib;
  logic [3:0]       odd;
  logic [1:0]       shamt;
  logic             gate;
  logic [ACC_W-1:0] partial;
  logic [ACC_W-1:0] acc_sum;
  logic             coef_hit;

  // Current tap and nibble: even idx -> high nibble, odd idx -> low nibble.
  always_comb begin
    tap = TAP_W'(idx_q >> 1);
    nib = idx_q[0] ? coef_q[tap][3:0] : coef_q[tap][7:4];
  end

  // Split nibble into odd * 2^shamt; a zero nibble gates the partial.
  always_comb begin
    gate  = (nib == 4'd0);
    shamt = 2'd0;
    if (nib[0])      shamt = 2'd0;
    else if (nib[1]) shamt = 2'd1;
    else if (nib[2]) shamt = 2'd2;
    else             shamt = 2'd3;
    odd = nib >> shamt;
  end

  // Shifted, gated partial, weighted by nibble position, added to acc.
  always_comb begin
    partial = gate ? '0 : (ACC_W'(mux_out) << shamt);
    acc_sum = idx_q[0] ? (acc_q + partial) : (acc_q + (partial << 4));
  end

  // Shared-datapath control; only meaningful while in MAC.
  always_comb begin
    in_ready   = (state_q == S_IDLE);
    tap_sample = d_q[0];
    mux_select = 3'd0;
    if (state_q == S_MAC) begin
      tap_sample = d_q[tap];
      if (!gate) mux_select = odd[3:1];
    end
  end

  assign coef_hit = coef_we && ({1'b0, coef_addr} < 5'(TAPS));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_MAC;
      S_MAC:   if (idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register plus datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      idx_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int unsigned i = 0; i < TAPS; i++) begin
        coef_q[i] <= '0;
        d_q[i]    <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          // Write lands on the same edge as the accept, so it applies here.
          if (coef_hit) coef_q[coef_addr[TAP_W-1:0]] <= coef_data;
          if (in_valid) begin
            d_q[0] <= in_data;
            for (int unsigned i = 1; i < TAPS; i++) d_q[i] <= d_q[i-1];
            acc_q <= '0;
            idx_q <= '0;
          end
        end
        S_MAC: begin
          acc_q <= acc_sum;
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            out_data  <= acc_sum;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cshm_fir_seq.sv
// Directed bench for cshm_fir_seq (TAPS=4). A behavioural precomputer/mux
// returns tap_sample * (2*mux_select+1) in the same cycle.
module tb_cshm_fir_seq;

  localparam int unsigned TAPS  = 4;
  localparam int unsigned ACC_W = 18;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             coef_we;
  logic [3:0]       coef_addr;
  logic [7:0]       coef_data;
  logic [7:0]       tap_sample;
  logic [2:0]       mux_select;
  logic [15:0]      mux_out;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  int tests = 0;
  int fails = 0;
  logic [2:0] selq [8];
  logic [7:0] tapq [8];

  cshm_fir_seq #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .tap_sample (tap_sample),
    .mux_select (mux_select),
    .mux_out    (mux_out),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  assign mux_out = 16'({8'd0, tap_sample} * {12'd0, mux_select, 1'b1});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wcoef(input logic [3:0] a, input logic [7:0] v);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a; coef_data = v;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // Offer one sample, record mux_select/tap_sample per MAC cycle, check the
  // latency and result, and optionally complete the output handshake.
  task automatic run_sample(input logic [7:0] s, input int expv, input string tag,
                            input bit release_out);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_data = s;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    selq[0] = mux_select;
    tapq[0] = tap_sample;
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat < 8) begin
        selq[lat] = mux_select;
        tapq[lat] = tap_sample;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'd8);
    chk({tag, "_data"}, 32'(out_data), 32'(expv));
    if (release_out) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    bit seen;
    int lat;
    // Reset with strobes active: nothing may be written or accepted.
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'd99;
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'h55; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; coef_we = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_mux_select", 32'(mux_select), 32'd0);
    chk("rst_tap_sample", 32'(tap_sample), 32'd0);

    // Coefficients still zero after reset; flush the delay line afterwards.
    run_sample(8'd200, 0, "rst_nocoef", 1'b1);
    for (int i = 0; i < 4; i++) run_sample(8'd0, 0, "flush", 1'b1);

    // Impulse response with all coefficients 0x01.
    for (int i = 0; i < 4; i++) wcoef(4'(i), 8'h01);
    run_sample(8'd10, 10, "imp0", 1'b1);
    run_sample(8'd0,  10, "imp1", 1'b1);
    run_sample(8'd0,  10, "imp2", 1'b1);
    run_sample(8'd0,  10, "imp3", 1'b1);
    run_sample(8'd0,  0,  "imp4", 1'b1);

    // Full scale: 255 * 0xFF. Out-of-range address must be ignored.
    wcoef(4'd1, 8'h00); wcoef(4'd2, 8'h00); wcoef(4'd3, 8'h00);
    wcoef(4'd0, 8'hFF); wcoef(4'd9, 8'h77);
    run_sample(8'd255, 65025, "full", 1'b1);
    chk("full_sel0", 32'(selq[0]), 32'd7);
    chk("full_sel1", 32'(selq[1]), 32'd7);
    chk("full_sel2", 32'(selq[2]), 32'd0);
    chk("full_sel7", 32'(selq[7]), 32'd0);

    // Shift decode: 0x80 = 1<<3 in the high nibble; 0x0C = 3<<2 low nibble.
    wcoef(4'd0, 8'h80);
    run_sample(8'd3, 384, "shift8", 1'b1);
    chk("shift8_sel0", 32'(selq[0]), 32'd0);
    wcoef(4'd0, 8'h0C);
    run_sample(8'd5, 60, "shiftC", 1'b1);
    chk("shiftC_sel1", 32'(selq[1]), 32'd1);
    chk("shiftC_tap0", 32'(tapq[0]), 32'd5);
    chk("shiftC_tap1", 32'(tapq[2]), 32'd3);
    chk("shiftC_tap2", 32'(tapq[4]), 32'd255);

    // Backpressure: DONE held 5 cycles while strobes pulse.
    wcoef(4'd1, 8'h01);
    run_sample(8'd7, 89, "bp", 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'd100;
      coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'hFF;
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'(out_data), 32'd89);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    run_sample(8'd2, 31, "bp_after", 1'b1);

    // Reset at idx=3 of a MAC run.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd9;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (lat < 3) begin
      @(negedge clk);
      lat++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_idle", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_valid", 32'(seen), 32'd0);
    run_sample(8'd50, 0, "midrst_cleared", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cshm_fir_seq.md
# cshm_fir_seq

Sequencer for the computation-sharing-multiplier (CSHM) FIR datapath. It holds the sample delay line and the coefficient bank. For each accepted input sample it walks every tap one 4-bit coefficient nibble per cycle. For each nibble it drives the shared odd-multiple 8:1 multiplexor select, then shifts, gates and accumulates the returned multiple. It sits between the sample source and the filter output, and owns the only control path into the shared precomputer/mux pair.

## Interface
- TAPS, 8: number of filter taps (2..16).
- ACC_W, 20: accumulator and output width; must be ≥ 16 + clog2(TAPS).

- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_data  in  8  unsigned input sample.
- in_valid  in  1  sample offered.
- in_ready  out  1  block accepts a sample (high only in IDLE).
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  4  tap index (values ≥ TAPS ignored).
- coef_data  in  8  unsigned coefficient.
- tap_sample  out  8  delay-line sample fed to the precomputer for the current tap.
- mux_select  out  3  select to the odd-multiple mux (0→x1, 1→x3 … 7→x15).
- mux_out  in  16  selected multiple returned combinationally, same cycle.
- out_data  out  ACC_W  filter result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.

## Operation
- States: IDLE, MAC, DONE.
- IDLE:
  - in_ready=1.
  - When coef_we=1 and coef_addr<TAPS, write coef[coef_addr].
  - When in_valid=1, accept the sample:
    - delay line shifts: d[0]←in_data, d[i]←d[i-1].
    - acc←0, idx←0, go to MAC.
  - When coef_we and in_valid are both high in the same cycle, the write lands first, so the new coefficient applies to this sample.
- MAC, 2·TAPS cycles, idx = 0 … 2·TAPS-1:
  - tap = idx>>1. Even idx uses the high nibble, odd idx uses the low nibble of coef[tap].
  - tap_sample=d[tap].
  - Nibble decode for n≠0: n = odd·2^s with odd ∈ {1,3,…,15} and s ∈ 0..3.
    - mux_select=(odd-1)>>1.
    - partial = mux_out << s.
  - n=0: mux_select=0 and partial=0 (gated).
  - acc += partial << 4 for a high nibble, partial << 0 for a low nibble.
  - After idx=2·TAPS-1: out_data←final acc, out_valid←1, go to DONE.
- DONE:
  - out_data and out_valid are held stable until out_ready=1.
  - On out_ready=1: out_valid←0, go to IDLE.
- In MAC and DONE, coef_we and in_valid are ignored: writes are dropped, no sample is consumed.
- Arithmetic is unsigned throughout.
  - partial ≤ 15·255 fits 16 bits.
  - A per-tap product ≤ 65025.
  - The ACC_W constraint guarantees no overflow. No saturation logic.
- In IDLE and DONE, tap_sample=d[0] and mux_select=0; these are don't-care for the datapath.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, mux_select=0, tap_sample=0, acc=0. All delay-line entries and all coefficients are 0.
- Reset asserted in any state:
  - Returns to IDLE at that edge.
  - Any sample in progress is discarded.
  - A pending out_valid drops.
- Latency: sample accepted at edge k. First MAC cycle runs between edges k and k+1. out_valid rises at edge k+2·TAPS.
- Throughput: one sample per 2·TAPS+2 cycles when out_ready is held high (MAC + DONE + IDLE accept cycle).
- mux_out is sampled in the same cycle that mux_select and tap_sample are driven. There is no pipeline register on the shared datapath.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 and coef_we=1.
  - Expect in_ready=1, out_valid=0, out_data=0 after release.
  - Expect no coefficient written.
- Impulse, TAPS=4, all coef=0x01: feed samples 10, 0, 0, 0, 0.
  - Expect outputs 10, 10, 10, 10, 0.
  - Each output at exactly 8 edges after its accept.
- Full-scale, coef[0]=0xFF, others 0: sample 255.
  - Expect out_data=65025.
  - Expect mux_select=7 on both tap-0 MAC cycles and 0 on the gated zero-nibble cycles.
- Shift decode: coef[0]=0x80, sample 3.
  - Expect a high-nibble cycle with mux_select=0 and a shift of 3.
  - Expect out_data=384.
  - Repeat with coef 0x0C (odd=3, s=2), sample 5: expect 60.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, while pulsing in_valid and coef_we.
  - Expect out_data stable, in_ready=0, delay line and coefficients unchanged.
  - The next sample is accepted only after the DONE→IDLE handoff.
- Reset mid-MAC: assert rst_n=0 at idx=3.
  - Expect IDLE next cycle, out_valid never rises, coefficients cleared.
  - A following sample with coef=0 yields out_data=0.
